solar_multi_ch_monitor: RTL

Parametrised successor to the single-instance solar panel monitor. Scans NUM_CH panel channels round-robin and requests samples from an external ADC front end over a req/ack handshake. Box-car averages 2^AVG_LOG2 samples per channel and streams each average out over a valid/ready interface. Tracks per-channel under-threshold faults (shading or disconnect) with a consecutive-count filter and raises an interrupt. Sits inside the user project, between the ADC interface logic and the Wishbone/LA register layer.

---
 rtl/solar_multi_ch_monitor.sv | 135 +++++++++++++
 1 files changed

// File: rtl/solar_multi_ch_monitor.sv
// solar_multi_ch_monitor: round-robin ADC scanner with box-car averaging, fault filter and irq.
// Optional SOLAR_MON_PEAK_EN adds per-channel peak-hold registers (peak_o, peak_clr_i).
module solar_multi_ch_monitor #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 12,
    parameter int AVG_LOG2  = 3,
    parameter int FAULT_CNT = 4,
    parameter int TIMEOUT   = 255,
    localparam int CH_W     = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              en_i,
    input  logic [DATA_W-1:0] thresh_i,
    output logic              adc_req_o,
    output logic [CH_W-1:0]   adc_ch_o,
    input  logic              adc_ack_i,
    input  logic [DATA_W-1:0] adc_data_i,
    output logic              avg_valid_o,
    input  logic              avg_ready_i,
    output logic [CH_W-1:0]   avg_ch_o,
    output logic [DATA_W-1:0] avg_data_o,
    output logic [NUM_CH-1:0] fault_o,
    input  logic [NUM_CH-1:0] fault_clr_i,
    output logic              irq_o,
`ifdef SOLAR_MON_PEAK_EN
    output logic [NUM_CH*DATA_W-1:0] peak_o,
    input  logic [NUM_CH-1:0]        peak_clr_i,
`endif
    output logic              timeout_o
);
    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int LOW_W = 4;

    typedef enum logic [2:0] {IDLE, REQ, GAP, SKIP, EMIT} state_t;
    state_t state, state_nxt;

    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic [TMR_W-1:0]  tmr;
    logic [CH_W-1:0]   ch;
    logic [LOW_W-1:0]  low_cnt [NUM_CH];
    logic [LOW_W-1:0]  low_nxt [NUM_CH];
    logic [NUM_CH-1:0] fault_nxt;
    logic [DATA_W-1:0] avg;
    logic              take, expire, xfer;

    assign avg         = DATA_W'(acc >> AVG_LOG2);
    assign take        = state == REQ && adc_ack_i;
    assign expire      = state == REQ && !adc_ack_i && tmr == TMR_W'(TIMEOUT - 1);
    assign xfer        = state == EMIT && avg_ready_i;
    assign adc_req_o   = state == REQ;
    assign adc_ch_o    = ch;
    assign avg_valid_o = state == EMIT;
    assign avg_ch_o    = ch;
    assign avg_data_o  = avg_valid_o ? avg : '0;

    // SKIP is the post-timeout slot: unlike GAP it honours en_i immediately.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = en_i ? REQ : IDLE;
            REQ:     state_nxt = take ? GAP : expire ? SKIP : REQ;
            GAP:     state_nxt = cnt < CNT_W'(1 << AVG_LOG2) ? REQ : EMIT;
            SKIP:    state_nxt = en_i ? REQ : IDLE;
            EMIT:    state_nxt = avg_ready_i ? (en_i ? REQ : IDLE) : EMIT;
            default: state_nxt = IDLE;
        endcase
    end

    // A transferring channel's filter update overrides its clear, so a set always wins.
    always_comb begin
        fault_nxt = fault_o & ~fault_clr_i;
        for (int i = 0; i < NUM_CH; i++) begin
            low_nxt[i] = fault_clr_i[i] ? '0 : low_cnt[i];
            if (xfer && ch == CH_W'(i)) begin
                if (avg < thresh_i) begin
                    low_nxt[i]   = (low_cnt[i] == LOW_W'(FAULT_CNT)) ? low_cnt[i] : low_cnt[i] + 1'b1;
                    fault_nxt[i] = (low_nxt[i] == LOW_W'(FAULT_CNT)) | fault_o[i];
                end else begin
                    low_nxt[i]   = '0;
                    fault_nxt[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state     <= IDLE;
            ch        <= '0;
            acc       <= '0;
            cnt       <= '0;
            tmr       <= '0;
            low_cnt   <= '{default: '0};
            fault_o   <= '0;
            irq_o     <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            state   <= state_nxt;
            low_cnt <= low_nxt;
            fault_o <= fault_nxt;
            irq_o   <= |(fault_nxt & ~fault_o);
            tmr     <= (state == REQ && !take && !expire) ? tmr + 1'b1 : '0;
            if (take) begin
                acc <= acc + ACC_W'(adc_data_i);
                cnt <= cnt + 1'b1;
            end
            if (expire || xfer) begin
                acc <= '0;
                cnt <= '0;
                ch  <= (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + 1'b1;
            end
            if (expire) timeout_o <= 1'b1;
        end
    end

`ifdef SOLAR_MON_PEAK_EN
    logic [DATA_W-1:0] peak [NUM_CH];

    always_ff @(posedge wb_clk_i) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (!wb_rst_ni) peak[i] <= '0;
            else if (xfer && ch == CH_W'(i)) peak[i] <= (peak_clr_i[i] || avg > peak[i]) ? avg : peak[i];
            else if (peak_clr_i[i]) peak[i] <= '0;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_peak
        assign peak_o[g*DATA_W +: DATA_W] = peak[g];
    end
`endif
endmodule
